// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect tone player: FSM encodings, note step limits,
// the silence level and a helper that picks the step limit for the note being played.
package sfx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t NOTE_A = 2'd1;
  localparam state_t NOTE_B = 2'd2;

  localparam int unsigned LIM_W = 12;

  // Step limits: a ROM step lasts LIM+1 cycles, 32 steps per sine period at 50 MHz.
  localparam logic [LIM_W-1:0] LIM_C = 12'hBAA;
  localparam logic [LIM_W-1:0] LIM_D = 12'hA64;
  localparam logic [LIM_W-1:0] LIM_E = 12'h941;
  localparam logic [LIM_W-1:0] LIM_G = 12'h7C9;

  localparam logic [3:0] SILENCE = 4'd8;

  // two_note selects the C/E effect; otherwise the single G note is played.
  function automatic logic [LIM_W-1:0] note_limit(input state_t st, input logic two_note);
    logic [LIM_W-1:0] lim;
    if (st == NOTE_B) begin
      lim = LIM_E;
    end else if (two_note) begin
      lim = LIM_C;
    end else begin
      lim = LIM_G;
    end
    return lim;
  endfunction

endpackage

// File: rtl/sfx_sine_rom.sv
// 32-entry, 4-bit sine table with a registered output; value(k) = round(7.5 + 7.5*sin(2*pi*k/32)).
module sfx_sine_rom
  import sfx_pkg::*;
(
  input  logic       clk,
  input  logic [4:0] addr,
  output logic [3:0] data
);

  logic [3:0] rom_val;

  always_comb begin
    rom_val = SILENCE;
    case (addr)
      5'd0:  rom_val = 4'd8;
      5'd1:  rom_val = 4'd9;
      5'd2:  rom_val = 4'd10;
      5'd3:  rom_val = 4'd12;
      5'd4:  rom_val = 4'd13;
      5'd5:  rom_val = 4'd14;
      5'd6:  rom_val = 4'd14;
      5'd7:  rom_val = 4'd15;
      5'd8:  rom_val = 4'd15;
      5'd9:  rom_val = 4'd15;
      5'd10: rom_val = 4'd14;
      5'd11: rom_val = 4'd14;
      5'd12: rom_val = 4'd13;
      5'd13: rom_val = 4'd12;
      5'd14: rom_val = 4'd10;
      5'd15: rom_val = 4'd9;
      5'd16: rom_val = 4'd8;
      5'd17: rom_val = 4'd6;
      5'd18: rom_val = 4'd5;
      5'd19: rom_val = 4'd3;
      5'd20: rom_val = 4'd2;
      5'd21: rom_val = 4'd1;
      5'd22: rom_val = 4'd1;
      5'd23: rom_val = 4'd0;
      5'd24: rom_val = 4'd0;
      5'd25: rom_val = 4'd0;
      5'd26: rom_val = 4'd1;
      5'd27: rom_val = 4'd1;
      5'd28: rom_val = 4'd2;
      5'd29: rom_val = 4'd3;
      5'd30: rom_val = 4'd5;
      5'd31: rom_val = 4'd6;
      default: rom_val = SILENCE;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_val;
  end

endmodule

// File: rtl/sfx_tone_player.sv
// Plays a short note sequence on paddle/brick events as a 4-bit sine sample stream.
// Optional decay envelope: define SFX_ENVELOPE_EN.
module sfx_tone_player
  import sfx_pkg::*;
#(
  parameter int unsigned NOTE_LEN = 5_000_000,
  parameter int unsigned LEN_W    = 23
) (
  input  logic       clk50mhz,
  input  logic       reset_button,
  input  logic       play_sound1,
  input  logic       play_sound2,
  output logic [3:0] tono,
  output logic       busy
);

  localparam logic [LEN_W-1:0] DUR_LAST = LEN_W'(NOTE_LEN - 1);

  logic [1:0]       sync1_q, sync2_q;
  logic             prev1_q, prev2_q;
  logic             rise1, rise2;

  state_t           state_q, state_d;
  logic             seq_q, seq_d;
  logic [LEN_W-1:0] dur_q, dur_d;
  logic [LIM_W-1:0] step_q, step_d;
  logic [4:0]       addr_q, addr_d;
  logic [LIM_W-1:0] note_lim;

  logic [4:0]       rom_addr;
  logic [3:0]       rom_data;
  logic [3:0]       shaped;
  logic [3:0]       tono_q;

  // Two-flop synchronizer followed by a rising-edge detector on each event line.
  always_ff @(posedge clk50mhz) begin
    if (reset_button) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
    end else begin
      sync1_q <= {sync1_q[0], play_sound1};
      sync2_q <= {sync2_q[0], play_sound2};
      prev1_q <= sync1_q[1];
      prev2_q <= sync2_q[1];
    end
  end

  assign rise1 = sync1_q[1] & ~prev1_q;
  assign rise2 = sync2_q[1] & ~prev2_q;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    dur_d    = dur_q;
    step_d   = step_q;
    addr_d   = addr_q;
    note_lim = note_limit(state_q, seq_q);
    if (rise1 || rise2) begin
      // Newest event wins; brick hit has priority on a simultaneous rise.
      state_d = NOTE_A;
      seq_d   = rise2;
      dur_d   = '0;
      step_d  = '0;
      addr_d  = '0;
    end else if (state_q != IDLE) begin
      if (dur_q == DUR_LAST) begin
        dur_d   = '0;
        step_d  = '0;
        addr_d  = '0;
        state_d = (state_q == NOTE_A && seq_q) ? NOTE_B : IDLE;
      end else begin
        dur_d = dur_q + 1'b1;
        if (step_q == note_lim) begin
          step_d = '0;
          addr_d = addr_q + 5'd1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (reset_button) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      dur_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      dur_q   <= dur_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
    end
  end

  // The ROM is fed the next address so its registered output always matches addr_q.
  assign rom_addr = reset_button ? 5'd0 : addr_d;

  sfx_sine_rom u_rom (
    .clk  (clk50mhz),
    .addr (rom_addr),
    .data (rom_data)
  );

`ifdef SFX_ENVELOPE_EN
  logic [LEN_W+1:0] dur_x4;
  logic [1:0]       quarter;
  logic signed [4:0] centred, scaled;

  localparam logic [LEN_W+1:0] Q1 = (LEN_W + 2)'(NOTE_LEN);
  localparam logic [LEN_W+1:0] Q2 = (LEN_W + 2)'(2 * NOTE_LEN);
  localparam logic [LEN_W+1:0] Q3 = (LEN_W + 2)'(3 * NOTE_LEN);

  assign dur_x4 = {dur_q, 2'b00};

  // quarter = floor(dur*4/NOTE_LEN) without a divider.
  always_comb begin
    quarter = 2'd0;
    if (dur_x4 >= Q3) begin
      quarter = 2'd3;
    end else if (dur_x4 >= Q2) begin
      quarter = 2'd2;
    end else if (dur_x4 >= Q1) begin
      quarter = 2'd1;
    end
  end

  assign centred = $signed({1'b0, rom_data}) - 5'sd8;
  assign scaled  = centred >>> quarter;
  assign shaped  = 4'(scaled + 5'sd8);
`else
  assign shaped = rom_data;
`endif

  always_ff @(posedge clk50mhz) begin
    if (reset_button) begin
      tono_q <= SILENCE;
    end else if (state_q == IDLE) begin
      tono_q <= SILENCE;
    end else begin
      tono_q <= shaped;
    end
  end

  assign tono = tono_q;
  assign busy = (state_q != IDLE);

endmodule
